// File: rtl/spi_frame_rx.sv
// SPI slave frame receiver. spi_clk/spi_cs/spi_out are oversampled in the clk domain,
// one FRAME_W-bit word is assembled per chip-select window, and bad frame lengths are flagged.
module spi_frame_rx #(
    parameter int FRAME_W     = 48,
    parameter bit CPOL        = 1'b0,
    parameter bit CPHA        = 1'b0,
    parameter bit MSB_FIRST   = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               spi_clk,
    input  logic               spi_cs,
    input  logic               spi_out,
    output logic [FRAME_W-1:0] spi_rdata,
    output logic               rdata_valid,
    output logic               frame_err,
    output logic               busy,
    output logic [7:0]         err_cnt
);
    localparam int                 CNT_W    = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]   OVR_CNT  = CNT_W'(FRAME_W + 1);
    localparam logic [FRAME_W-1:0] ONE_LSB  = FRAME_W'(1);
    localparam logic [FRAME_W-1:0] ONE_MSB  = ONE_LSB << (FRAME_W - 1);

    typedef enum logic [1:0] {ARM, IDLE, SHIFT, CHECK} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [FRAME_W-1:0]     r_shift;
    logic [CNT_W-1:0]       r_bit_cnt;

    logic                   w_sclk;
    logic                   w_cs;
    logic                   w_bit;
    logic                   w_cs_rise;
    logic                   w_sample;
    logic                   w_clear;
    logic                   w_shift;
    logic [FRAME_W-1:0]     w_mask;

    // The cs chain resets to "selected" so ARM must see a real deselect before the first frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= {SYNC_STAGES{CPOL}};
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_d    <= CPOL;
            r_cs_d      <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_out};
            r_sclk_d    <= w_sclk;
            r_cs_d      <= w_cs;
        end
    end

    assign w_sclk    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs      = r_cs_sync[SYNC_STAGES-1];
    assign w_bit     = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs_rise = w_cs & ~r_cs_d;
    assign w_sample  = (CPOL == CPHA) ? (w_sclk & ~r_sclk_d) : (~w_sclk & r_sclk_d);
    assign w_mask    = MSB_FIRST ? (ONE_MSB >> r_bit_cnt) : (ONE_LSB << r_bit_cnt);
    assign busy      = (r_state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ARM;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A cs rise wins over a sample edge seen in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            ARM: begin
                if (w_cs) begin
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                if (!w_cs) begin
                    w_state_nxt = SHIFT;
                    w_clear     = 1'b1;
                end
            end
            SHIFT: begin
                if (w_cs_rise) begin
                    w_state_nxt = CHECK;
                end else if (w_sample) begin
                    w_shift = 1'b1;
                end
            end
            CHECK: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = ARM;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            spi_rdata   <= '0;
            rdata_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_cnt     <= '0;
        end else begin
            rdata_valid <= 1'b0;
            frame_err   <= 1'b0;
            if (w_clear) begin
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else if (w_shift) begin
                if (r_bit_cnt < FULL_CNT) begin
                    r_shift   <= w_bit ? (r_shift | w_mask) : (r_shift & ~w_mask);
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end else begin
                    r_bit_cnt <= OVR_CNT;
                end
            end
            // Only an exact-length frame replaces the published word.
            if (r_state == CHECK) begin
                if (r_bit_cnt == FULL_CNT) begin
                    spi_rdata   <= r_shift;
                    rdata_valid <= 1'b1;
                end else begin
                    frame_err <= 1'b1;
                    if (err_cnt != 8'hFF) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_rx.sv
// Bench for spi_frame_rx: one 48-bit MSB-first receiver plus 16-bit LSB-first receivers in all
// four SPI modes, checked each cycle against a frame-level model and a few literal expectations.
module tb_spi_frame_rx;
    localparam int S = 2;
    localparam int N = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sclk0 = 1'b0;
    logic sclk1;
    logic cs48 = 1'b1;
    logic cs16 = 1'b1;
    logic mosi = 1'b0;

    logic [47:0] rd0;
    logic [15:0] rd16 [1:4];
    logic [N-1:0] dv, dfe, dbz;
    logic [7:0]  dec [N];
    logic [63:0] act_rd [N];

    int cyc  = 0;
    int nvec = 0;
    int nmis = 0;

    // frame-level model state
    int          fw      [N];
    bit          msbf    [N];
    int          grp_of  [N];
    logic [63:0] exp_rd  [N];
    int          exp_ec  [N];
    bit          ready   [N];
    bit          live    [N];
    int          busy_from [N];
    int          busy_to   [N];
    bit          pend      [N];
    int          pend_cyc  [N];
    bit          pend_good [N];
    logic [63:0] pend_word [N];

    assign sclk1 = ~sclk0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_frame_rx #(.FRAME_W(48), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b1), .SYNC_STAGES(S)) dut0 (
        .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs(cs48), .spi_out(mosi),
        .spi_rdata(rd0), .rdata_valid(dv[0]), .frame_err(dfe[0]), .busy(dbz[0]), .err_cnt(dec[0]));
    spi_frame_rx #(.FRAME_W(16), .CPOL(1'b0), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(S)) dut1 (
        .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs(cs16), .spi_out(mosi),
        .spi_rdata(rd16[1]), .rdata_valid(dv[1]), .frame_err(dfe[1]), .busy(dbz[1]), .err_cnt(dec[1]));
    spi_frame_rx #(.FRAME_W(16), .CPOL(1'b0), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(S)) dut2 (
        .clk(clk), .rst(rst), .spi_clk(sclk0), .spi_cs(cs16), .spi_out(mosi),
        .spi_rdata(rd16[2]), .rdata_valid(dv[2]), .frame_err(dfe[2]), .busy(dbz[2]), .err_cnt(dec[2]));
    spi_frame_rx #(.FRAME_W(16), .CPOL(1'b1), .CPHA(1'b0), .MSB_FIRST(1'b0), .SYNC_STAGES(S)) dut3 (
        .clk(clk), .rst(rst), .spi_clk(sclk1), .spi_cs(cs16), .spi_out(mosi),
        .spi_rdata(rd16[3]), .rdata_valid(dv[3]), .frame_err(dfe[3]), .busy(dbz[3]), .err_cnt(dec[3]));
    spi_frame_rx #(.FRAME_W(16), .CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0), .SYNC_STAGES(S)) dut4 (
        .clk(clk), .rst(rst), .spi_clk(sclk1), .spi_cs(cs16), .spi_out(mosi),
        .spi_rdata(rd16[4]), .rdata_valid(dv[4]), .frame_err(dfe[4]), .busy(dbz[4]), .err_cnt(dec[4]));

    assign act_rd[0] = {16'h0, rd0};
    assign act_rd[1] = {48'h0, rd16[1]};
    assign act_rd[2] = {48'h0, rd16[2]};
    assign act_rd[3] = {48'h0, rd16[3]};
    assign act_rd[4] = {48'h0, rd16[4]};

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] msb_seq(input logic [63:0] word, input int w);
        logic [63:0] s = '0;
        for (int i = 0; i < w; i++) s[i] = word[w-1-i];
        return s;
    endfunction

    task automatic ev_reset();
        for (int d = 0; d < N; d++) begin
            exp_rd[d] = '0; exp_ec[d] = 0; pend[d] = 1'b0; live[d] = 1'b0;
            ready[d] = 1'b0; busy_from[d] = 0; busy_to[d] = 0;
        end
    endtask

    task automatic ev_release();
        for (int d = 0; d < N; d++) ready[d] = (grp_of[d] == 0) ? cs48 : cs16;
    endtask

    task automatic ev_fall(input int g);
        for (int d = 0; d < N; d++) begin
            if (grp_of[d] == g) begin
                live[d]  = ready[d];
                ready[d] = 1'b0;
                if (live[d]) begin
                    busy_from[d] = cyc + S + 1;
                    busy_to[d]   = 1 << 30;
                end
            end
        end
    endtask

    // seq[i] is the i-th bit on the wire; the model places it by the receiver's bit order.
    task automatic ev_rise(input int g, input logic [63:0] seq, input int n);
        logic [63:0] w;
        for (int d = 0; d < N; d++) begin
            if (grp_of[d] == g) begin
                if (live[d]) begin
                    busy_to[d]   = cyc + S + 1;
                    pend[d]      = 1'b1;
                    pend_cyc[d]  = cyc + S + 2;
                    pend_good[d] = (n == fw[d]);
                    w = '0;
                    for (int i = 0; i < fw[d]; i++) begin
                        if (msbf[d]) w[fw[d]-1-i] = seq[i];
                        else         w[i] = seq[i];
                    end
                    pend_word[d] = w;
                end
                live[d]  = 1'b0;
                ready[d] = 1'b1;
            end
        end
    endtask

    task automatic send(input int g, input logic [63:0] seq, input int n, input int rst_after);
        if (g == 0) cs48 = 1'b0; else cs16 = 1'b0;
        ev_fall(g);
        tick(4);
        for (int i = 0; i < n; i++) begin
            mosi = seq[i];
            tick(3);
            sclk0 = 1'b1;
            tick(3);
            sclk0 = 1'b0;
            tick(3);
            if (i + 1 == rst_after) begin
                rst = 1'b1;
                ev_reset();
                tick(3);
                rst = 1'b0;
                ev_release();
                tick(2);
            end
        end
        if (g == 0) cs48 = 1'b1; else cs16 = 1'b1;
        ev_rise(g, seq, n);
    endtask

    always @(negedge clk) begin
        logic ev, ef, eb;
        for (int d = 0; d < N; d++) begin
            ev = 1'b0;
            ef = 1'b0;
            if (!rst && pend[d] && cyc == pend_cyc[d]) begin
                pend[d] = 1'b0;
                if (pend_good[d]) begin
                    exp_rd[d] = pend_word[d];
                    ev = 1'b1;
                end else begin
                    ef = 1'b1;
                    if (exp_ec[d] < 255) exp_ec[d] = exp_ec[d] + 1;
                end
            end
            eb = !rst && cyc >= busy_from[d] && cyc < busy_to[d];
            nvec++;
            if (act_rd[d] !== exp_rd[d] || dv[d] !== ev || dfe[d] !== ef || dbz[d] !== eb ||
                dec[d] !== 8'(exp_ec[d])) begin
                nmis++;
                $display("FAIL cycle %0d dut%0d: got rdata=%h valid=%b err=%b busy=%b err_cnt=%0d, expected rdata=%h valid=%b err=%b busy=%b err_cnt=%0d",
                         cyc, d, act_rd[d], dv[d], dfe[d], dbz[d], dec[d],
                         exp_rd[d], ev, ef, eb, exp_ec[d]);
            end
        end
    end

    initial begin
        fw     = '{48, 16, 16, 16, 16};
        msbf   = '{1, 0, 0, 0, 0};
        grp_of = '{0, 1, 1, 1, 1};
        ev_reset();

        tick(5);
        check("reset rdata", act_rd[0], 64'h0);
        check("reset valid", {63'h0, dv[0]}, 64'h0);
        check("reset err_cnt", {56'h0, dec[0]}, 64'h0);
        rst = 1'b0;
        ev_release();
        tick(5);

        // mode 0, 48 bits MSB-first, pulse exactly 4 clk after cs rise
        send(0, msb_seq(64'hA5A5_1234_F00F, 48), 48, 0);
        tick(3);
        check("valid not early", {63'h0, dv[0]}, 64'h0);
        tick(1);
        check("valid at cs+4", {63'h0, dv[0]}, 64'h1);
        check("rdata 48b", act_rd[0], 64'hA5A5_1234_F00F);
        tick(4);

        // LSB-first 16-bit words in all four modes
        send(1, 64'h8001, 16, 0);
        tick(6);
        for (int k = 1; k <= 4; k++) check($sformatf("mode%0d 8001", k - 1), act_rd[k], 64'h8001);
        send(1, 64'h1234, 16, 0);
        tick(6);
        for (int k = 1; k <= 4; k++) check($sformatf("mode%0d 1234", k - 1), act_rd[k], 64'h1234);

        // short then long frame
        send(0, msb_seq(64'hDEAD_BEEF_0123, 48), 47, 0);
        tick(5);
        send(0, 64'h1_5555_AAAA_5555, 49, 0);
        tick(6);
        check("err_cnt after 47/49", {56'h0, dec[0]}, 64'd2);
        check("rdata kept", act_rd[0], 64'hA5A5_1234_F00F);

        // back-to-back frames, cs high for 3 clk
        send(0, msb_seq(64'h0123_4567_89AB, 48), 48, 0);
        tick(3);
        send(0, msb_seq(64'hFEDC_BA98_7654, 48), 48, 0);
        tick(6);
        check("back-to-back 2nd", act_rd[0], 64'hFEDC_BA98_7654);

        // reset mid-frame: partial frame must never be captured
        send(0, msb_seq(64'h5A5A_5A5A_5A5A, 48), 48, 20);
        tick(4);
        send(0, msb_seq(64'h1111_2222_3333, 48), 48, 0);
        tick(6);
        check("after mid reset", act_rd[0], 64'h1111_2222_3333);
        check("err_cnt cleared", {56'h0, dec[0]}, 64'h0);

        // zero-bit frames drive err_cnt into saturation
        for (int k = 0; k < 256; k++) begin
            send(0, 64'h0, 0, 0);
            tick(4);
        end
        tick(6);
        check("err_cnt saturates", {56'h0, dec[0]}, 64'd255);
        check("rdata after errors", act_rd[0], 64'h1111_2222_3333);

        tick(5);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
